// File: rtl/a0_trace_pkg.sv
// Shared types and constants for the a0 trace buffer.
// Optional feature macro: A0_TRACE_DROPCNT_EN (adds the drop_cnt output).
package a0_trace_pkg;

    localparam int PKG_TS_W   = 16;
    localparam int PKG_DATA_W = 32;
    localparam int DROPCNT_W  = 16;

    typedef struct packed {
        logic [PKG_TS_W-1:0]   ts;
        logic [PKG_DATA_W-1:0] a0;
    } trace_entry_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROPCNT_W-1:0] sat_inc(input logic [DROPCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/trace_sync_fifo.sv
// First-word-fall-through synchronous FIFO holding {ts, a0} trace entries.
// The head slot is presented combinationally; the output reads zero while empty.
module trace_sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A write into a full FIFO is allowed only when the head leaves in the same cycle.
    assign do_rd = pop & ~empty & ~clr;
    assign do_wr = push & (~full | do_rd) & ~clr;

    // Pointers wrap naturally at DEPTH; clear rewinds both.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy tracked separately from the pointers so full and empty are unambiguous.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else begin
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/a0_trace_fifo.sv
// Captures every change of the CPU a0 result as a {timestamp, value} entry and
// streams the entries out over valid/ready. The CPU side never stalls: entries
// arriving while full are dropped and flagged on the sticky overflow output.
// Optional feature macro: A0_TRACE_DROPCNT_EN (adds a saturating drop_cnt output).
module a0_trace_fifo
    import a0_trace_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int TS_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cap_en,
    input  logic [DATA_WIDTH-1:0]    a0_in,
    input  logic                     clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_a0,
    output logic [TS_WIDTH-1:0]      out_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
`ifdef A0_TRACE_DROPCNT_EN
    ,
    output logic [DROPCNT_W-1:0]     drop_cnt
`endif
);

    logic [TS_WIDTH-1:0]            ts;
    logic [DATA_WIDTH-1:0]          last_a0;
    logic                           change;
    logic                           push;
    logic                           pop;
    logic                           drop;
    logic                           fifo_empty;
    logic                           fifo_full;
    logic [TS_WIDTH+DATA_WIDTH-1:0] head;

    // Free-running cycle stamp and previous a0 for change detection; neither is touched by clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts      <= '0;
            last_a0 <= '0;
        end else begin
            ts      <= ts + 1'b1;
            last_a0 <= a0_in;
        end
    end

    assign change = (a0_in != last_a0);
    assign push   = change & cap_en & ~clr;
    assign pop    = out_valid & out_ready;
    assign drop   = push & fifo_full & ~pop;

    // Sticky loss flag, cleared only by clr or reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      overflow <= 1'b0;
        else if (clr)  overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

`ifdef A0_TRACE_DROPCNT_EN
    // Counts dropped entries, holding at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      drop_cnt <= '0;
        else if (clr)  drop_cnt <= '0;
        else if (drop) drop_cnt <= sat_inc(drop_cnt);
    end
`endif

    trace_sync_fifo #(
        .WIDTH (TS_WIDTH + DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .wdata ({ts, a0_in}),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (count)
    );

    assign out_valid = ~fifo_empty;
    assign out_ts    = head[TS_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign out_a0    = head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_a0_trace_fifo.sv
// Scoreboard bench for a0_trace_fifo: a reference model turns each cycle's inputs
// into expected entries on a queue; a monitor pops and compares on every handshake.
module tb_a0_trace_fifo;
    import a0_trace_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cap_en;
    logic [31:0] a0_in;
    logic        clr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a0;
    logic [15:0] out_ts;
    logic [4:0]  count;
    logic        overflow;
`ifdef A0_TRACE_DROPCNT_EN
    logic [15:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    a0_trace_fifo #(.DATA_WIDTH(32), .DEPTH(DEPTH), .TS_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cap_en    (cap_en),
        .a0_in     (a0_in),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a0    (out_a0),
        .out_ts    (out_ts),
        .count     (count),
        .overflow  (overflow)
`ifdef A0_TRACE_DROPCNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    trace_entry_t exp_q[$];
    logic [31:0]  m_last;
    logic [15:0]  m_ts;
    bit           m_ovf;
    int           m_drop;
    bit           popped;
    int           occ;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            m_last = '0;
            m_ts   = '0;
            m_ovf  = 1'b0;
            m_drop = 0;
            popped = 1'b0;
        end else begin
            occ = exp_q.size() + (popped ? 1 : 0);
            if (clr) begin
                exp_q.delete();
                m_ovf  = 1'b0;
                m_drop = 0;
            end else if (cap_en && a0_in != m_last) begin
                if (occ == DEPTH && !popped) begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end else begin
                    exp_q.push_back('{ts: m_ts, a0: a0_in});
                end
            end
            popped = 1'b0;
            m_last = a0_in;
            m_ts   = m_ts + 16'd1;
        end
    end

    // ---------------- monitor ----------------
    trace_entry_t got_e;
    always @(negedge clk) begin
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        chk("count", 64'(count), 64'(exp_q.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
`ifdef A0_TRACE_DROPCNT_EN
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
`endif
        if (out_valid && out_ready && exp_q.size() != 0) begin
            got_e = exp_q.pop_front();
            chk("out_a0", 64'(out_a0), 64'(got_e.a0));
            chk("out_ts", 64'(out_ts), 64'(got_e.ts));
            popped = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int thr;

    initial begin
        rst       = 1'b0;
        cap_en    = 1'b1;
        clr       = 1'b0;
        out_ready = 1'b1;
        a0_in     = '0;
        cyc(2);
        rst = 1'b1;

        // a0 held at zero: nothing captured
        cyc(20);
        chk("idle_count", 64'(count), 64'd0);

        // single change, first-word-fall-through latency of one cycle
        a0_in = 32'd5;
        cyc(1);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_a0", 64'(out_a0), 64'd5);
        cyc(3);
        chk("lat_empty", 64'(out_valid), 64'd0);

        // 17 changes into a stalled sink: one dropped
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            a0_in = 32'd100 + 32'(i);
            cyc(1);
        end
        cyc(1);
        chk("full_count", 64'(count), 64'd16);
        chk("full_ovf", 64'(overflow), 64'd1);

        // push and pop together while full
        a0_in     = 32'd999;
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        chk("full_pushpop", 64'(count), 64'd16);
        chk("new_head", 64'(out_a0), 64'd101);
        out_ready = 1'b1;
        cyc(20);
        chk("drained", 64'(count), 64'd0);

        // clr with a concurrent change
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a0_in = 32'd200 + 32'(i);
            cyc(1);
        end
        clr   = 1'b1;
        a0_in = 32'd777;
        cyc(1);
        clr = 1'b0;
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_ovf", 64'(overflow), 64'd0);
        chk("clr_valid", 64'(out_valid), 64'd0);
        cyc(2);

        // reset in the middle of a drain
        for (int i = 0; i < 8; i++) begin
            a0_in = 32'd300 + 32'(i);
            cyc(1);
        end
        out_ready = 1'b1;
        cyc(2);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        cyc(2);
        a0_in = 32'd42;
        rst   = 1'b1;
        cyc(1);
        chk("ts_restart", 64'(out_ts), 64'd0);
        chk("ts_restart_a0", 64'(out_a0), 64'd42);
        cyc(2);

        // randomized traffic with varying sink throughput
        for (int blk = 0; blk < 6; blk++) begin
            thr = $urandom_range(5, 95);
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(0, 2) != 0) a0_in = 32'($urandom_range(0, 5));
                cap_en    = ($urandom_range(0, 9) != 0);
                out_ready = ($urandom_range(0, 99) < thr);
                clr       = ($urandom_range(0, 299) == 0);
                cyc(1);
            end
        end

        clr       = 1'b0;
        cap_en    = 1'b0;
        out_ready = 1'b1;
        cyc(40);
        chk("final_empty", 64'(count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
